xrbus_time_sync_ctrl: RTL and testbench

Periodic snapshot scheduler for the XR-BUS timing contract layer. It owns the device, fabric and cloud timestamp sources. It issues one coordinated snapshot request per sync period, collects the three timestamps over independent req/ack channels with a timeout, and presents a coherent triple to the alignment datapath over a valid/ready handshake. It sits between the per-domain timestamp synchronizers and the alignment/drift logic.

---
 rtl/xrbus_timing_pkg.sv | 25 ++
 rtl/xrbus_snap_chan.sv | 48 ++++
 rtl/xrbus_time_sync_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_xrbus_time_sync_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xrbus_timing_pkg.sv
// xrbus_timing_pkg
// Shared definitions for the XR-BUS time sync controller: scheduler state
// encoding, timestamp source indices and a saturating counter helper.
// Optional feature macro used by the top level: XRBUS_SYNC_STATS_EN.
package xrbus_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_PRESENT = 2'd3
  } sync_state_e;

  localparam int NUM_SRC  = 3;
  localparam int SRC_DEV  = 0;
  localparam int SRC_FAB  = 1;
  localparam int SRC_CLD  = 2;
  localparam int TS_W_DEF = 64;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/xrbus_snap_chan.sv
// xrbus_snap_chan
// One timestamp source channel: owns the source's request bit and captures
// the timestamp presented alongside the acknowledge.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       open a new request (clears any previous capture)
//   abort       drop the request and forget the capture
//   ack         one-cycle acknowledge from the source
//   ts          source timestamp, valid with ack
//   req         request to the source
//   done        this round's timestamp has been captured
//   ts_q        captured timestamp
module xrbus_snap_chan
  import xrbus_timing_pkg::*;
#(
  parameter int TS_W = TS_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            ack,
  input  logic [TS_W-1:0] ts,
  output logic            req,
  output logic            done,
  output logic [TS_W-1:0] ts_q
);

  // An ack only counts while the request is outstanding; stray acks are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req  <= 1'b0;
      done <= 1'b0;
      ts_q <= '0;
    end else if (abort) begin
      req  <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      req  <= 1'b1;
      done <= 1'b0;
    end else if (req && ack) begin
      req  <= 1'b0;
      done <= 1'b1;
      ts_q <= ts;
    end
  end

endmodule

// File: rtl/xrbus_time_sync_ctrl.sv
// xrbus_time_sync_ctrl
// Periodic snapshot scheduler: once per sync period it requests device,
// fabric and cloud timestamps, collects them under a timeout and presents
// the coherent triple downstream over a valid/ready handshake.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   enable                     run the scheduler
//   sync_period                cycles between rounds (0 behaves as 1)
//   snap_req / snap_ack        per-source request / one-cycle acknowledge
//   dev_ts, fab_ts, cld_ts     source timestamps, sampled on their ack
//   out_valid / out_ready      output handshake
//   out_dev_ts/fab_ts/cld_ts   captured triple
//   out_seq                    sequence number of the presented triple
//   timeout_err                one-cycle pulse on a timed-out round
//   missed_src                 sources that did not ack in the last timeout
//   busy                       scheduler not idle
//   timeout_cnt, max_ack_lat   statistics, only with XRBUS_SYNC_STATS_EN
// Optional macro: XRBUS_SYNC_STATS_EN adds the statistics ports and logic.
module xrbus_time_sync_ctrl
  import xrbus_timing_pkg::*;
#(
  parameter int TS_W    = TS_W_DEF,
  parameter int TIMEOUT = 1024,
  parameter int SEQ_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [31:0]      sync_period,
  output logic [2:0]       snap_req,
  input  logic [2:0]       snap_ack,
  input  logic [TS_W-1:0]  dev_ts,
  input  logic [TS_W-1:0]  fab_ts,
  input  logic [TS_W-1:0]  cld_ts,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TS_W-1:0]  out_dev_ts,
  output logic [TS_W-1:0]  out_fab_ts,
  output logic [TS_W-1:0]  out_cld_ts,
  output logic [SEQ_W-1:0] out_seq,
  output logic             timeout_err,
  output logic [2:0]       missed_src,
`ifdef XRBUS_SYNC_STATS_EN
  output logic [15:0]      timeout_cnt,
  output logic [15:0]      max_ack_lat,
`endif
  output logic             busy
);

  sync_state_e state, state_next;

  logic [31:0]        per_cnt;
  logic [31:0]        per_lim;
  logic [31:0]        tmo_cnt;
  logic [NUM_SRC-1:0] chan_done;
  logic [NUM_SRC-1:0] ack_hit;
  logic [NUM_SRC-1:0] pending_after;
  logic [TS_W-1:0]    chan_ts_q [NUM_SRC];
  logic               got_all;
  logic               tmo_hit;
  logic               per_hit;
  logic               enter_wait;
  logic               start;
  logic               abort;
  logic               do_timeout;
  logic               do_complete;
  logic               do_accept;

  xrbus_snap_chan #(.TS_W(TS_W)) u_chan_dev (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .ack   (snap_ack[SRC_DEV]),
    .ts    (dev_ts),
    .req   (snap_req[SRC_DEV]),
    .done  (chan_done[SRC_DEV]),
    .ts_q  (chan_ts_q[SRC_DEV])
  );

  xrbus_snap_chan #(.TS_W(TS_W)) u_chan_fab (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .ack   (snap_ack[SRC_FAB]),
    .ts    (fab_ts),
    .req   (snap_req[SRC_FAB]),
    .done  (chan_done[SRC_FAB]),
    .ts_q  (chan_ts_q[SRC_FAB])
  );

  xrbus_snap_chan #(.TS_W(TS_W)) u_chan_cld (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .ack   (snap_ack[SRC_CLD]),
    .ts    (cld_ts),
    .req   (snap_req[SRC_CLD]),
    .done  (chan_done[SRC_CLD]),
    .ts_q  (chan_ts_q[SRC_CLD])
  );

  // Acks landing this cycle count as received, even on the timeout cycle.
  assign ack_hit       = snap_ack & snap_req;
  assign got_all       = &(chan_done | ack_hit);
  assign pending_after = snap_req & ~snap_ack;
  assign tmo_hit       = (tmo_cnt == 32'(TIMEOUT - 1));
  assign per_hit       = (per_cnt == per_lim);
  assign enter_wait    = (state_next == ST_WAIT) && (state != ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Disable wins over completion and timeout while collecting, so an
  // aborted round never reports an error or produces output.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    abort       = 1'b0;
    do_timeout  = 1'b0;
    do_complete = 1'b0;
    do_accept   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (per_hit) begin
          state_next = ST_COLLECT;
          start      = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (!enable) begin
          state_next = ST_IDLE;
          abort      = 1'b1;
        end else if (got_all) begin
          state_next  = ST_PRESENT;
          do_complete = 1'b1;
        end else if (tmo_hit) begin
          state_next = ST_WAIT;
          abort      = 1'b1;
          do_timeout = 1'b1;
        end
      end
      ST_PRESENT: begin
        if (out_valid && out_ready) begin
          do_accept  = 1'b1;
          state_next = enable ? ST_WAIT : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The period is latched when WAIT is entered so mid-count changes only
  // affect the following round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      per_lim <= '0;
    end else if (enter_wait) begin
      per_cnt <= '0;
      per_lim <= (sync_period == 32'd0) ? 32'd0 : sync_period - 32'd1;
    end else if (state == ST_WAIT) begin
      per_cnt <= per_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (start) begin
      tmo_cnt <= '0;
    end else if (state == ST_COLLECT) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  // Sources that ack in the completing cycle bypass the channel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dev_ts <= '0;
      out_fab_ts <= '0;
      out_cld_ts <= '0;
    end else if (do_complete) begin
      out_dev_ts <= chan_done[SRC_DEV] ? chan_ts_q[SRC_DEV] : dev_ts;
      out_fab_ts <= chan_done[SRC_FAB] ? chan_ts_q[SRC_FAB] : fab_ts;
      out_cld_ts <= chan_done[SRC_CLD] ? chan_ts_q[SRC_CLD] : cld_ts;
    end else if (state_next == ST_IDLE) begin
      out_dev_ts <= '0;
      out_fab_ts <= '0;
      out_cld_ts <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      missed_src  <= '0;
      out_seq     <= '0;
    end else begin
      out_valid   <= (state_next == ST_PRESENT);
      busy        <= (state_next != ST_IDLE);
      timeout_err <= do_timeout;
      if (do_timeout) begin
        missed_src <= pending_after;
      end else if (do_complete) begin
        missed_src <= '0;
      end
      if (do_accept) begin
        out_seq <= out_seq + SEQ_W'(1);
      end
    end
  end

`ifdef XRBUS_SYNC_STATS_EN
  logic [15:0] lat_now;

  // The timeout counter at completion is the req-rise-to-final-ack latency.
  assign lat_now = (tmo_cnt > 32'h0000_FFFF) ? 16'hFFFF : tmo_cnt[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
      max_ack_lat <= '0;
    end else begin
      if (do_timeout) begin
        timeout_cnt <= sat_inc16(timeout_cnt);
      end
      if (do_complete && (lat_now > max_ack_lat)) begin
        max_ack_lat <= lat_now;
      end
    end
  end
`endif

endmodule

// File: tb/tb_xrbus_time_sync_ctrl.sv
// tb_xrbus_time_sync_ctrl
// Self-checking bench for xrbus_time_sync_ctrl. Acts as the three timestamp
// sources and the downstream consumer; expected timing and data come from
// per-round arithmetic on the chosen ack delays.
module tb_xrbus_time_sync_ctrl;

  localparam int TS_W    = 64;
  localparam int TIMEOUT = 16;
  localparam int SEQ_W   = 4;
  localparam int NEVER   = 1000000;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [31:0]      sync_period;
  logic [2:0]       snap_req;
  logic [2:0]       snap_ack;
  logic [TS_W-1:0]  src_ts [3];
  logic             out_valid;
  logic             out_ready;
  logic [TS_W-1:0]  out_dev_ts;
  logic [TS_W-1:0]  out_fab_ts;
  logic [TS_W-1:0]  out_cld_ts;
  logic [SEQ_W-1:0] out_seq;
  logic             timeout_err;
  logic [2:0]       missed_src;
  logic             busy;
`ifdef XRBUS_SYNC_STATS_EN
  logic [15:0]      timeout_cnt;
  logic [15:0]      max_ack_lat;
`endif

  int n_checks;
  int n_fail;
  int cyc;
  int wait_start;
  int exp_seq;
  logic [2:0] exp_missed;
  int tmo_total;
  int max_lat_exp;
  logic [TS_W-1:0] exp_ts [3];

  xrbus_time_sync_ctrl #(
    .TS_W    (TS_W),
    .TIMEOUT (TIMEOUT),
    .SEQ_W   (SEQ_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sync_period (sync_period),
    .snap_req    (snap_req),
    .snap_ack    (snap_ack),
    .dev_ts      (src_ts[0]),
    .fab_ts      (src_ts[1]),
    .cld_ts      (src_ts[2]),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_dev_ts  (out_dev_ts),
    .out_fab_ts  (out_fab_ts),
    .out_cld_ts  (out_cld_ts),
    .out_seq     (out_seq),
    .timeout_err (timeout_err),
    .missed_src  (missed_src),
`ifdef XRBUS_SYNC_STATS_EN
    .timeout_cnt (timeout_cnt),
    .max_ack_lat (max_ack_lat),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pval(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait for the next request rise and confirm it lands P cycles into WAIT.
  task automatic waitReqRise(input int p_lat, input bit mid_change);
    int n;
    n = 0;
    while (snap_req == 3'b000 && n < 400) begin
      if (mid_change && n == 1) sync_period = $urandom_range(0, 40);
      tick();
      n++;
      if (snap_req == 3'b000) begin
        checkOutput("wait_valid", 64'(out_valid), 64'd0);
        checkOutput("wait_err", 64'(timeout_err), 64'd0);
      end
    end
    checkOutput("req_rise", 64'(snap_req), 64'd7);
    checkOutput("req_rise_cycle", 64'(cyc), 64'(wait_start + p_lat));
    checkOutput("req_rise_busy", 64'(busy), 64'd1);
  endtask

  // One collect round from the request-rise cycle: ack delays per source
  // (NEVER = no ack), backpressure length, optional stray re-acks, and the
  // sync_period to latch for the next WAIT.
  task automatic applyStimulus(input int d0, input int d1, input int d2,
                               input int rdy_wait, input bit spurious, input int next_p);
    int d [3];
    int maxd;
    bit complete;
    logic [2:0] ack;
    logic [2:0] exp_req;
    d[0] = d0; d[1] = d1; d[2] = d2;
    maxd = d0;
    if (d1 > maxd) maxd = d1;
    if (d2 > maxd) maxd = d2;
    complete = (maxd <= TIMEOUT - 1);
    sync_period = next_p;
    for (int k = 0; k < TIMEOUT; k++) begin
      for (int i = 0; i < 3; i++) begin
        src_ts[i] = rand64();
        ack[i] = (k == d[i]) || (spurious && k == d[i] + 2);
        if (k == d[i]) exp_ts[i] = src_ts[i];
      end
      snap_ack = ack;
      tick();
      for (int i = 0; i < 3; i++) exp_req[i] = (k + 1 <= d[i]) && (k + 1 < TIMEOUT);
      checkOutput("collect_req", 64'(snap_req), 64'(exp_req));
      checkOutput("collect_err", 64'(timeout_err), 64'(!complete && (k + 1 == TIMEOUT)));
      checkOutput("collect_valid", 64'(out_valid), 64'(complete && (k >= maxd)));
      if ((complete && k == maxd) || (!complete && k == TIMEOUT - 1)) break;
    end
    snap_ack = 3'b000;
    if (complete) begin
      if (maxd > max_lat_exp) max_lat_exp = maxd;
      for (int w = 0; w <= rdy_wait; w++) begin
        out_ready = (w == rdy_wait);
        src_ts[0] = rand64();
        src_ts[1] = rand64();
        src_ts[2] = rand64();
        snap_ack = 3'($urandom_range(0, 7));
        checkOutput("present_valid", 64'(out_valid), 64'd1);
        checkOutput("present_dev", out_dev_ts, exp_ts[0]);
        checkOutput("present_fab", out_fab_ts, exp_ts[1]);
        checkOutput("present_cld", out_cld_ts, exp_ts[2]);
        checkOutput("present_seq", 64'(out_seq), 64'(exp_seq));
        checkOutput("present_req", 64'(snap_req), 64'd0);
        checkOutput("present_missed", 64'(missed_src), 64'd0);
        tick();
      end
      out_ready = 1'b0;
      snap_ack = 3'b000;
      exp_seq = (exp_seq + 1) % (1 << SEQ_W);
      exp_missed = 3'b000;
      checkOutput("accept_valid", 64'(out_valid), 64'd0);
      checkOutput("accept_seq", 64'(out_seq), 64'(exp_seq));
      checkOutput("accept_busy", 64'(busy), 64'd1);
    end else begin
      for (int i = 0; i < 3; i++) exp_missed[i] = (d[i] > TIMEOUT - 1);
      tmo_total++;
      checkOutput("tmo_missed", 64'(missed_src), 64'(exp_missed));
      checkOutput("tmo_seq", 64'(out_seq), 64'(exp_seq));
      checkOutput("tmo_busy", 64'(busy), 64'd1);
    end
    wait_start = cyc;
  endtask

  // Drop enable in the middle of a collect round, then re-enable.
  task automatic abortRound(input int next_p);
    src_ts[0] = rand64();
    snap_ack = 3'b001;
    tick();
    snap_ack = 3'b000;
    checkOutput("abort_req_partial", 64'(snap_req), 64'd6);
    enable = 1'b0;
    tick();
    checkOutput("abort_req", 64'(snap_req), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_err", 64'(timeout_err), 64'd0);
    checkOutput("abort_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_ts", out_dev_ts, 64'd0);
    checkOutput("abort_seq", 64'(out_seq), 64'(exp_seq));
    checkOutput("idle_missed_hold", 64'(missed_src), 64'(exp_missed));
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      tick();
      checkOutput("idle_err", 64'(timeout_err), 64'd0);
      checkOutput("idle_busy", 64'(busy), 64'd0);
    end
    sync_period = next_p;
    enable = 1'b1;
    tick();
    checkOutput("reenable_busy", 64'(busy), 64'd1);
    wait_start = cyc;
  endtask

  initial begin
    int p_cur;
    int p_next;
    int dd [3];
    n_checks = 0; n_fail = 0; cyc = 0; exp_seq = 0; exp_missed = 3'b000;
    tmo_total = 0; max_lat_exp = 0;
    rst_n = 1'b0; enable = 1'b0; sync_period = 32'd0; snap_ack = 3'b000; out_ready = 1'b0;
    src_ts[0] = '0; src_ts[1] = '0; src_ts[2] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req", 64'(snap_req), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_seq", 64'(out_seq), 64'd0);
    checkOutput("rst_err", 64'(timeout_err), 64'd0);
    checkOutput("rst_missed", 64'(missed_src), 64'd0);
    checkOutput("rst_ts", out_cld_ts, 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_busy0", 64'(busy), 64'd0);

    sync_period = 32'd4;
    enable = 1'b1;
    tick();
    wait_start = cyc;
    checkOutput("enable_busy", 64'(busy), 64'd1);

    $display("[TB] basic round");
    waitReqRise(4, 1'b0);
    applyStimulus(2, 2, 2, 0, 1'b0, 4);

    $display("[TB] staggered acks with stray re-acks");
    waitReqRise(4, 1'b1);
    applyStimulus(1, 9, 5, 0, 1'b1, 3);

    $display("[TB] backpressure");
    waitReqRise(3, 1'b0);
    applyStimulus(0, 0, 0, 10, 1'b0, 2);

    $display("[TB] final ack on the timeout cycle");
    waitReqRise(2, 1'b0);
    applyStimulus(0, TIMEOUT - 1, 3, 0, 1'b0, 1);

    $display("[TB] timeouts");
    waitReqRise(1, 1'b0);
    applyStimulus(0, 2, NEVER, 0, 1'b0, 5);
    waitReqRise(5, 1'b1);
    applyStimulus(TIMEOUT - 1, NEVER, 0, 0, 1'b0, 2);

    $display("[TB] abort mid-collect");
    waitReqRise(2, 1'b0);
    abortRound(0);

    $display("[TB] back-to-back rounds through sequence wrap");
    p_cur = 1;
    for (int r = 0; r < 17; r++) begin
      waitReqRise(p_cur, 1'b0);
      applyStimulus($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] randomized rounds");
    for (int r = 0; r < 24; r++) begin
      p_next = $urandom_range(0, 5);
      for (int i = 0; i < 3; i++)
        dd[i] = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, TIMEOUT - 1);
      waitReqRise(p_cur, 1'($urandom_range(0, 1)));
      applyStimulus(dd[0], dd[1], dd[2], $urandom_range(0, 3), 1'($urandom_range(0, 1)), p_next);
      p_cur = pval(p_next);
    end

`ifdef XRBUS_SYNC_STATS_EN
    checkOutput("stats_timeouts", 64'(timeout_cnt), 64'(tmo_total));
    checkOutput("stats_max_lat", 64'(max_ack_lat), 64'(max_lat_exp));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
